// File: rtl/ex_div.sv
// ex_div: iterative RV32M divider for the execute stage.
// Restoring division, one quotient bit per cycle. Operands are reduced to
// magnitudes on acceptance and the signs are reapplied to the final result.
// Divide-by-zero and signed overflow skip the iteration and finish in one cycle.
module ex_div #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic                      start_i,
  input  logic [1:0]                op_i,
  input  logic [DATA_WIDTH-1:0]     dividend_i,
  input  logic [DATA_WIDTH-1:0]     divisor_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  output logic                      busy_o,
  output logic                      result_valid_o,
  output logic [DATA_WIDTH-1:0]     result_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_reg;
  logic                      sel_rem_reg;   // op[1]: remainder requested
  logic                      neg_q_reg;
  logic                      neg_r_reg;
  logic [REG_ADDR_WIDTH-1:0] rd_pend_reg;   // rd of the op in flight
  logic [DATA_WIDTH-1:0]     rem_reg;
  logic [DATA_WIDTH-1:0]     quot_reg;      // holds |dividend| initially, shifts into quotient
  logic [DATA_WIDTH-1:0]     divisor_reg;
  logic [CNT_W-1:0]          count_reg;

  logic                      signed_op;
  logic                      accept;
  logic [DATA_WIDTH-1:0]     dividend_abs;
  logic [DATA_WIDTH-1:0]     divisor_abs;
  logic                      div_zero;
  logic                      overflow;
  logic                      special;
  logic [DATA_WIDTH-1:0]     special_result;
  logic [DATA_WIDTH:0]       shifted;
  logic [DATA_WIDTH:0]       diff;
  logic [DATA_WIDTH-1:0]     rem_next;
  logic [DATA_WIDTH-1:0]     quot_next;
  logic [DATA_WIDTH-1:0]     final_result;

  // Stall the pipeline from the start cycle until the last iteration;
  // released in DONE so the instruction advances with its writeback.
  assign accept = (state_reg == IDLE) & start_i & ~flush_i;
  assign busy_o = accept | (state_reg == CALC);

  // Operand preparation, special-case detection and one restoring step.
  always_comb begin
    signed_op      = ~op_i[0];
    dividend_abs   = (signed_op && dividend_i[DATA_WIDTH-1]) ? ('0 - dividend_i) : dividend_i;
    divisor_abs    = (signed_op && divisor_i[DATA_WIDTH-1])  ? ('0 - divisor_i)  : divisor_i;
    div_zero       = (divisor_i == '0);
    overflow       = signed_op && (dividend_i == MIN_NEG) && (divisor_i == '1);
    special        = div_zero | overflow;
    special_result = '0;
    if (div_zero) begin
      special_result = op_i[1] ? dividend_i : '1;
    end else if (overflow) begin
      special_result = op_i[1] ? '0 : MIN_NEG;
    end

    // Partial remainder is always below the divisor, so a (W+1)-bit
    // difference cannot set its top bit unless the subtract borrowed.
    shifted   = {rem_reg, quot_reg[DATA_WIDTH-1]};
    diff      = shifted - {1'b0, divisor_reg};
    rem_next  = '0;
    quot_next = '0;
    if (diff[DATA_WIDTH]) begin
      rem_next  = shifted[DATA_WIDTH-1:0];
      quot_next = {quot_reg[DATA_WIDTH-2:0], 1'b0};
    end else begin
      rem_next  = diff[DATA_WIDTH-1:0];
      quot_next = {quot_reg[DATA_WIDTH-2:0], 1'b1};
    end

    if (sel_rem_reg) begin
      final_result = neg_r_reg ? ('0 - rem_next) : rem_next;
    end else begin
      final_result = neg_q_reg ? ('0 - quot_next) : quot_next;
    end
  end

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      sel_rem_reg    <= 1'b0;
      neg_q_reg      <= 1'b0;
      neg_r_reg      <= 1'b0;
      rd_pend_reg    <= '0;
      rem_reg        <= '0;
      quot_reg       <= '0;
      divisor_reg    <= '0;
      count_reg      <= '0;
      result_valid_o <= 1'b0;
      result_o       <= '0;
      rd_addr_o      <= '0;
    end else begin
      result_valid_o <= 1'b0;
      if (flush_i) begin
        // Abort: no pulse, previous result/rd stay visible.
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start_i) begin
              sel_rem_reg <= op_i[1];
              neg_q_reg   <= signed_op & (dividend_i[DATA_WIDTH-1] ^ divisor_i[DATA_WIDTH-1]);
              neg_r_reg   <= signed_op & dividend_i[DATA_WIDTH-1];
              rd_pend_reg <= rd_addr_i;
              rem_reg     <= '0;
              quot_reg    <= dividend_abs;
              divisor_reg <= divisor_abs;
              count_reg   <= '0;
              if (special) begin
                result_o       <= special_result;
                rd_addr_o      <= rd_addr_i;
                result_valid_o <= 1'b1;
                state_reg      <= DONE;
              end else begin
                state_reg <= CALC;
              end
            end
          end
          CALC: begin
            rem_reg   <= rem_next;
            quot_reg  <= quot_next;
            count_reg <= count_reg + 1'b1;
            if (count_reg == LAST_COUNT) begin
              result_o       <= final_result;
              rd_addr_o      <= rd_pend_reg;
              result_valid_o <= 1'b1;
              state_reg      <= DONE;
            end
          end
          DONE: begin
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed vectors for ex_div with a queue-based scoreboard.
// Stimulus pushes the expected result, rd and completion cycle; a monitor
// pops and compares on every result_valid_o pulse.
module tb_ex_div;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic        busy_o;
  logic        result_valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_checks;
  int   n_fails;

  ex_div #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_i),
    .start_i        (start_i),
    .op_i           (op_i),
    .dividend_i     (dividend_i),
    .divisor_i      (divisor_i),
    .rd_addr_i      (rd_addr_i),
    .busy_o         (busy_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .rd_addr_o      (rd_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest expectation, on its cycle.
  always @(negedge clk) begin
    if (result_valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'(result_valid_o), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result_o, e.res);
        chk("rd_addr", 32'(rd_addr_o), 32'(e.rd));
        chk("valid_cycle", 32'(cyc), 32'(e.cyc));
        $display("result op rd=%0d res=%h at cycle %0d", rd_addr_o, result_o, cyc);
      end
    end
  end

  task automatic push_exp(input logic [31:0] res, input logic [4:0] rd, input int at);
    exp_t e;
    e.res = res;
    e.rd  = rd;
    e.cyc = at;
    sb.push_back(e);
  endtask

  // Issue one op from the current cycle and wait until it has completed.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat);
    int c;
    c = cyc;
    push_exp(exp, rd, c + lat);
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd;
    @(negedge clk);
    chk("busy_start", 32'(busy_o), 32'd1);
    @(posedge clk); #1;
    start_i = 1'b0;
    if (lat > 1) begin
      repeat (lat - 2) @(posedge clk);
      @(negedge clk);
      chk("busy_last_calc", 32'(busy_o), 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("busy_done", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    n_checks = 0; n_fails = 0;
    rst_n = 1'b0; flush_i = 1'b0; start_i = 1'b0; op_i = 2'd0;
    dividend_i = '0; divisor_i = '0; rd_addr_i = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(result_valid_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd", 32'(rd_addr_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal 33-cycle path
    do_op(OP_DIVU, 32'd100,        32'd7, 5'd5,  32'd14,         33);
    do_op(OP_DIV,  32'hFFFF_FFF9,  32'd2, 5'd6,  32'hFFFF_FFFD,  33);
    do_op(OP_REM,  32'hFFFF_FFF9,  32'd2, 5'd7,  32'hFFFF_FFFF,  33);
    do_op(OP_REMU, 32'hFFFF_FFF9,  32'd2, 5'd8,  32'd1,          33);
    do_op(OP_DIV,  32'd20, 32'hFFFF_FFFD, 5'd9,  32'hFFFF_FFFA,  33);
    do_op(OP_REM,  32'd20, 32'hFFFF_FFFD, 5'd10, 32'd2,          33);
    // Divide by zero, signed overflow: one-cycle path
    do_op(OP_DIV,  32'd42,   32'd0, 5'd11, 32'hFFFF_FFFF, 1);
    do_op(OP_REM,  32'd42,   32'd0, 5'd12, 32'd42,        1);
    do_op(OP_REMU, 32'd1000, 32'd0, 5'd13, 32'd1000,      1);
    do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
    do_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0,         1);
    do_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         33);

    // Flush at cycle 10 of a DIVU, restart at cycle 12
    c0 = cyc;
    start_i = 1'b1; op_i = OP_DIVU; dividend_i = 32'd999; divisor_i = 32'd3; rd_addr_i = 5'd17;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(busy_o), 32'd0);
    chk("flush_rd_hold", 32'(rd_addr_o), 32'd16);
    @(posedge clk); #1;
    chk("restart_cycle", 32'(cyc - c0), 32'd12);
    do_op(OP_DIVU, 32'd1000, 32'd10, 5'd18, 32'd100, 33);

    // start_i held through CALC with different operands is ignored
    c0 = cyc;
    push_exp(32'd14, 5'd19, c0 + 33);
    start_i = 1'b1; op_i = OP_DIVU; dividend_i = 32'd100; divisor_i = 32'd7; rd_addr_i = 5'd19;
    @(posedge clk); #1;
    op_i = OP_REM; dividend_i = 32'd5; divisor_i = 32'd1; rd_addr_i = 5'd9;
    repeat (32) @(posedge clk);
    #1;
    start_i = 1'b0;
    @(posedge clk); #1;

    // Reset mid-operation at cycle 20
    c0 = cyc;
    start_i = 1'b1; op_i = OP_DIVU; dividend_i = 32'd77; divisor_i = 32'd7; rd_addr_i = 5'd20;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_valid", 32'(result_valid_o), 32'd0);
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_rd", 32'(rd_addr_o), 32'd0);
    repeat (20) @(posedge clk);
    #1;

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Iterative RV32M divider used by the execute stage, directly downstream of the ID/EX pipeline buffer.
- Consumes op_data1/op_data2, rd_addr and funct3[1:0] of a DIV/DIVU/REM/REMU instruction.
- Produces a 32-bit quotient or remainder using a restoring, 1-bit-per-cycle algorithm.
- Holds the pipeline through a stall request until the result is ready.

Parameters:
- DATA_WIDTH, 32, operand/result width; the iteration count equals DATA_WIDTH.
- REG_ADDR_WIDTH, 5, destination register address width.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- flush_i  input  1  pipeline flush; synchronous abort of any operation
- start_i  input  1  request to start a division (a decoded M-extension divide is in EX)
- op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (equal to funct3[1:0])
- dividend_i  input  DATA_WIDTH  rs1 value
- divisor_i  input  DATA_WIDTH  rs2 value
- rd_addr_i  input  REG_ADDR_WIDTH  destination register
- busy_o  output  1  stall request to pipeline control
- result_valid_o  output  1  one-cycle pulse; result_o/rd_addr_o valid
- result_o  output  DATA_WIDTH  quotient or remainder
- rd_addr_o  output  REG_ADDR_WIDTH  destination register of the completed op

Behaviour:
- Reset (rst_n=0 at clock edge):
  - state=IDLE.
  - busy_o=0, result_valid_o=0, result_o=0, rd_addr_o=0.
  - Internal registers cleared.
- States and transitions:
  - IDLE -> CALC on an edge with start_i=1, flush_i=0 and a normal case.
  - IDLE -> DONE on an edge with start_i=1, flush_i=0 and a special case.
  - CALC -> DONE after 32 iterations.
  - DONE -> IDLE unconditionally.
- Acceptance (IDLE, start_i=1, flush_i=0) latches:
  - op, rd_addr.
  - |dividend| and |divisor| when signed (op[0]=0); raw values when unsigned.
  - neg_q = signed & (dividend[31]^divisor[31]).
  - neg_r = signed & dividend[31].
  - count=0, partial remainder=0.
- Special cases at acceptance (go straight to DONE, result computed directly):
  - divisor==0: quotient=all ones (0xFFFFFFFF); remainder=dividend_i unchanged. Applies to both signed and unsigned.
  - Signed overflow (op DIV/REM, dividend=0x80000000, divisor=0xFFFFFFFF): quotient=0x80000000; remainder=0.
- CALC, one iteration per cycle:
  - Shift {rem,quot} left 1.
  - Trial-subtract the divisor, using a 33-bit subtract to keep the carry.
  - If no borrow, keep the difference and set quot[0]=1.
  - count increments; on count==31 the transition to DONE registers the final result.
  - Final result: quotient negated if neg_q; remainder negated if neg_r.
  - Selection: op[1] selects remainder, else quotient.
- DONE:
  - result_valid_o=1 for exactly one cycle; result_o and rd_addr_o are valid.
  - After DONE, result_o/rd_addr_o hold their values; result_valid_o=0.
- Latency from the start_i cycle to the result_valid_o cycle:
  - Normal case: 33 cycles.
  - Special case: 1 cycle.
- busy_o (combinational): busy_o = (IDLE & start_i & ~flush_i) | CALC.
  - busy_o is 0 in DONE, so the stalled instruction advances in the cycle its result is written back.
- start_i while in CALC or DONE is ignored; no queueing.
- flush_i=1 at any edge:
  - Next state=IDLE; result_valid_o=0.
  - No result is produced for the aborted op; result_o/rd_addr_o hold their old values.
  - flush_i has priority over start_i and over the DONE pulse.
- rst_n=0 mid-operation behaves as flush and also clears result_o/rd_addr_o.

Test Plan:
- DIVU 100/7, rd=5:
  - Start at cycle 0; busy_o=1 in cycles 0-32.
  - Cycle 33: result_valid_o=1, result_o=14, rd_addr_o=5, busy_o=0.
- DIV -7/2 -> result_o=0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). REMU 0xFFFFFFF9/2 -> 1. Each is valid at cycle 33.
- Divide by zero:
  - DIV 42/0 -> 0xFFFFFFFF; REM 42/0 -> 42.
  - Valid at cycle 1; busy_o high only in cycle 0.
- Overflow:
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0, both at cycle 1.
  - DIVU of the same operands -> 0 via the normal 33-cycle path.
- Flush:
  - flush_i=1 at cycle 10 of a DIVU -> state IDLE, busy_o=0 at cycle 11, no result_valid_o pulse.
  - A new start at cycle 12 completes correctly at cycle 45.
- Ignored start and reset:
  - start_i held high in CALC with changed operands -> first result unaffected.
  - rst_n=0 at cycle 20 -> all outputs 0 at cycle 21, no pulse.
